piradip_sample_buffer_sequencer: RTL

PIRADIP_SAMPLE_BUFFER_SEQUENCER -- requirements
Module: piradip_sample_buffer_sequencer

---
 rtl/piradip_sample_buffer_sequencer_if.sv | 28 ++
 rtl/piradip_sample_buffer_sequencer.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/piradip_sample_buffer_sequencer_if.sv
// piradip_sample_buffer_sequencer_if: sequencer-to-sample-buffer control bus.
//   stream_update       - one-cycle strobe; buffer latches the fields below
//   stream_active       - buffer should play (1) or stop (0)
//   stream_one_shot     - play the region once, then pulse stream_stopped
//   stream_start_offset - first word of the region to play
//   stream_end_offset   - last word of the region to play
//   stream_stopped      - buffer -> sequencer pulse at the end of a one-shot play
// The master modport is the sequencer side and the slave modport is the buffer side.
interface piradip_sample_buffer_sequencer_if #(
  parameter int OFFSET_WIDTH = 16
);
  logic                    stream_update;
  logic                    stream_active;
  logic                    stream_one_shot;
  logic [OFFSET_WIDTH-1:0] stream_start_offset;
  logic [OFFSET_WIDTH-1:0] stream_end_offset;
  logic                    stream_stopped;
  modport master (
    output stream_update, stream_active, stream_one_shot,
    output stream_start_offset, stream_end_offset,
    input  stream_stopped
  );
  modport slave (
    input  stream_update, stream_active, stream_one_shot,
    input  stream_start_offset, stream_end_offset,
    output stream_stopped
  );
endinterface

// File: rtl/piradip_sample_buffer_sequencer.sv
// piradip_sample_buffer_sequencer: plays a table of buffer segments, each repeated, optionally looping.
//   aclk, aresetn          - clock and asynchronous active-low reset
//   seg_wr_*               - segment table write port (start, end, repeat at seg_wr_idx)
//   num_segments           - number of table entries in use (1..NUM_SEGMENTS)
//   arm/abort/trigger      - control: arm from idle, start on a trigger rising edge, abort anytime
//   loop_forever           - wrap back to segment 0 instead of finishing
//   stream                 - buffer control bus (master side)
//   busy/done/cur_seg/seg_error - status
// Optional: define PIRADIP_SEQ_TRIGGER_SYNC_EN to pass trigger through a 2-flop synchronizer.
module piradip_sample_buffer_sequencer #(
  parameter  int OFFSET_WIDTH = 16,
  parameter  int NUM_SEGMENTS = 4,
  parameter  int REPEAT_WIDTH = 8,
  localparam int IDXW = (NUM_SEGMENTS > 1) ? $clog2(NUM_SEGMENTS) : 1
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    seg_wr_en,
  input  logic [IDXW-1:0]         seg_wr_idx,
  input  logic [OFFSET_WIDTH-1:0] seg_wr_start,
  input  logic [OFFSET_WIDTH-1:0] seg_wr_end,
  input  logic [REPEAT_WIDTH-1:0] seg_wr_repeat,
  input  logic [IDXW:0]           num_segments,
  input  logic                    arm,
  input  logic                    abort,
  input  logic                    trigger,
  input  logic                    loop_forever,
  piradip_sample_buffer_sequencer_if.master stream,
  output logic                    busy,
  output logic                    done,
  output logic [IDXW-1:0]         cur_seg,
  output logic                    seg_error
);
  typedef enum logic [2:0] {IDLE, ARMED, LOAD, RUN, FINISH} state_t;
  state_t state, state_n;
  logic [IDXW-1:0]         seg, seg_n;
  logic [REPEAT_WIDTH-1:0] rep, rep_n;
  logic [OFFSET_WIDTH-1:0] tab_start [NUM_SEGMENTS];
  logic [OFFSET_WIDTH-1:0] tab_end   [NUM_SEGMENTS];
  logic [REPEAT_WIDTH-1:0] tab_rep   [NUM_SEGMENTS];
  logic [OFFSET_WIDTH-1:0] start_q, end_q;
  logic trig_s, trig_q, trig_rise, load_bad, upd_q, active_q;
  logic num_ok, abort_hit, seg_done, bad_n, upd_load, upd_stop;
  // Table has no reset so a programmed sequence survives aresetn.
  always_ff @(posedge aclk)
    if (seg_wr_en && int'(seg_wr_idx) < NUM_SEGMENTS) begin
      tab_start[seg_wr_idx] <= seg_wr_start;
      tab_end[seg_wr_idx]   <= seg_wr_end;
      tab_rep[seg_wr_idx]   <= seg_wr_repeat;
    end
`ifdef PIRADIP_SEQ_TRIGGER_SYNC_EN
  logic [1:0] trig_sync;
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) trig_sync <= '0;
    else trig_sync <= {trig_sync[0], trigger};
  assign trig_s = trig_sync[1];
`else
  assign trig_s = trigger;
`endif
  assign trig_rise = trig_s & ~trig_q;
  assign num_ok    = num_segments != '0 && int'(num_segments) <= NUM_SEGMENTS;
  assign abort_hit = abort && state != IDLE;
  // A malformed segment skips its play and is treated like a finished one.
  assign seg_done  = (state == RUN && stream.stream_stopped) || (state == LOAD && load_bad);
  assign bad_n     = tab_end[seg_n] < tab_start[seg_n];
  assign upd_load  = state_n == LOAD && !bad_n;
  assign upd_stop  = abort_hit || state_n == FINISH;
  always_comb begin
    state_n = state;
    seg_n   = seg;
    rep_n   = rep;
    case (state)
      IDLE:    if (arm && num_ok) state_n = ARMED;
      ARMED:   if (trig_rise) begin
                 state_n = LOAD;
                 seg_n   = '0;
                 rep_n   = '0;
               end
      LOAD:    state_n = RUN;
      FINISH:  state_n = IDLE;
      default: ;
    endcase
    if (seg_done) begin
      if (rep < tab_rep[seg]) begin
        rep_n   = rep + 1'b1;
        state_n = LOAD;
      end else begin
        rep_n = '0;
        if (({1'b0, seg} + 1'b1) < num_segments) begin
          seg_n   = seg + 1'b1;
          state_n = LOAD;
        end else if (loop_forever) begin
          seg_n   = '0;
          state_n = LOAD;
        end else state_n = FINISH;
      end
    end
    if (abort_hit) begin
      state_n = IDLE;
      seg_n   = seg;
      rep_n   = rep;
    end
  end
  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      state     <= IDLE;
      seg       <= '0;
      rep       <= '0;
      trig_q    <= 1'b0;
      load_bad  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      seg_error <= 1'b0;
      upd_q     <= 1'b0;
      active_q  <= 1'b0;
      start_q   <= '0;
      end_q     <= '0;
    end else begin
      state    <= state_n;
      seg      <= seg_n;
      rep      <= rep_n;
      trig_q   <= trig_s;
      load_bad <= state_n == LOAD && bad_n;
      busy     <= state_n != IDLE;
      done     <= state_n == FINISH;
      upd_q    <= upd_load || upd_stop;
      if (upd_load) begin
        active_q <= 1'b1;
        start_q  <= tab_start[seg_n];
        end_q    <= tab_end[seg_n];
      end else if (upd_stop) active_q <= 1'b0;
      if (state_n == LOAD && bad_n) seg_error <= 1'b1;
      else if (state == IDLE && state_n == ARMED) seg_error <= 1'b0;
    end
  assign cur_seg                    = seg;
  assign stream.stream_update       = upd_q;
  assign stream.stream_active       = active_q;
  assign stream.stream_one_shot     = active_q;
  assign stream.stream_start_offset = start_q;
  assign stream.stream_end_offset   = end_q;
endmodule
